uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Controller that sequences and services the UART receiver.
- Generates the receiver's 16x oversampling enable `rx_enbl` from the system clock using a programmable divisor.
- Drives the receiver's parity-enable configuration `p_enbl`.
- Captures each validated byte (`flag`) into a 16-entry receive FIFO read by the host.
- Counts receiver NAK/feedback events (`fb`) and flags FIFO overrun.

It sits between the receiver and the host/register interface, and is the only block that drives the receiver's enable and configuration inputs.

## Interface
Parameters:
- `DIV_W`, 16, width of baud divisor.
- `DEPTH`, 16, FIFO depth (power of two).
- `AW`, 4, log2(DEPTH).

Ports:
- `clk` in 1: system clock.
- `areset` in 1: reset, synchronous and active-high. Despite the name, it is not asynchronous.
- `rx_en` in 1: receive enable; gates tick generation.
- `baud_div` in DIV_W: clk cycles per oversample tick.
- `par_en_cfg` in 1: requested parity enable.
- `clr_stats` in 1: clears `nak_cnt` and `overrun`.
- `rx_enbl` out 1: oversample tick to the receiver; its clock input.
- `p_enbl` out 1: parity enable to the receiver.
- `rx_dout` in 8: receiver data.
- `rx_flag` in 1: receiver byte-valid.
- `rx_fb` in 1: receiver feedback/NAK.
- `rd_en` in 1: host pop.
- `rd_data` out 8: FIFO head (first-word fall-through).
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `count` out AW+1: FIFO occupancy, 0..DEPTH.
- `overrun` out 1: sticky byte-dropped flag.
- `nak_pulse` out 1: one-clk pulse per NAK.
- `nak_cnt` out 8: saturating NAK count.

## Operation
Reset values:
- `rx_enbl`=0, `p_enbl`=0, `overrun`=0, `nak_pulse`=0, `nak_cnt`=0.
- `count`=0, `empty`=1, `full`=0, `rd_data`=0.
- All pointers, divider and capture registers cleared.
- Reset mid-frame discards FIFO contents and any pending edge. The receiver has its own reset.

Tick generator:
- `div_cnt` runs 0..eff_div-1, where eff_div = max(`baud_div`, 2).
- `rx_enbl` is a registered pulse, high for exactly one clk when `div_cnt`==eff_div-1 and `rx_en`=1.
- `rx_en`=0 holds `div_cnt` at 0 and `rx_enbl` at 0.
- A change to `baud_div` takes effect at the next wrap. If `div_cnt` ≥ new eff_div-1, the counter wraps at the next clk.

Parity config:
- `p_enbl` <= `par_en_cfg` only while `rx_en`=0, so it is never changed under a frame in flight.
- While `rx_en`=1, `p_enbl` holds its value.

Capture:
- `rx_dout`, `rx_flag` and `rx_fb` are registered once (`_q`), then edge-detected against a second register (`_qq`).
- Push when `flag_q & ~flag_qq`, writing `dout_q`.
- Push when full: the byte is dropped, `overrun` <= 1 and the FIFO is unchanged.
- Push and pop in the same cycle:
  - When full: both occur and `count` stays DEPTH, so no overrun.
  - When empty: push only.
- Pop: `rd_en` & ~`empty` advances `rd_ptr`. `rd_en` while empty is ignored.
- `rd_data` = mem[`rd_ptr`] when not empty; otherwise it holds 0.
- Pointers are AW bits and wrap modulo DEPTH. `full` = (`count`==DEPTH).

NAK:
- On `fb_q & ~fb_qq`: `nak_pulse`=1 for one clk, and `nak_cnt` increments, saturating at 255.

Stats clear:
- `clr_stats` clears first, then a same-cycle event applies. The result is `nak_cnt`=1 and/or `overrun`=1.

## Timing
- `rx_enbl` period is eff_div clks with a duty of one clk. The receiver state advances on each `rx_enbl` rising edge.
- Receiver outputs change shortly after a clk edge and are stable by the next one, so a single capture register is sufficient.
- `rx_flag` first sampled high at edge k → `flag_q`=1 after k → push at edge k+1 → `empty`=0 and `rd_data` valid after k+1. Latency is 2 clks.
- The receiver holds `flag` for ≥ 8 ticks, so with eff_div ≥ 2 exactly one push occurs per byte.
- Pop: `rd_en` at edge m → the new head appears on `rd_data` after m, and `count` decrements after m.
- `nak_pulse` is high in the clk following `fb_q` rising, i.e. 2 clks after `rx_fb` rises.

## Structure
- Shared package `uart_pkg`:
  - Constants `UART_OVERSAMPLE=16`, `RX_FIFO_DEPTH=16`, `NAK_CNT_MAX=8'hFF`.
  - Minimum divisor `DIV_MIN=2`.
- Sub-module `uart_rx_fifo`: synchronous FWFT FIFO with push, pop, data, count, full and empty. It is instantiated once.
- Tick generator, capture/edge-detect and stats logic live in `uart_rx_ctrl`.

## Test plan
- Tick generation: `baud_div`=10, `rx_en`=1 → `rx_enbl` pulses every 10 clks, each 1 clk wide. Values 0 and 1 give a period of 2 clks. `rx_en`=0 → no pulses.
- Parity gating: `rx_en`=1, `p_enbl`=0, toggle `par_en_cfg`=1 → `p_enbl` stays 0. Drop `rx_en` → `p_enbl`=1 after 1 clk.
- End-to-end: drive receiver frames carrying 0xA5 then 0x3C → FIFO `count`=2, `rd_data`=0xA5; `rd_en` → `rd_data`=0x3C; second `rd_en` → `empty`=1.
- Overrun: 17 bytes pushed without reads → `count`=16, `overrun`=1, head = first byte. Push with a simultaneous pop at full → `count` stays 16 and no new overrun.
- NAK counting: 3 frames with a stop bit of 0 → 3 `nak_pulse`s and `nak_cnt`=3. With 300 NAKs → `nak_cnt`=255. `clr_stats` with a same-cycle NAK → `nak_cnt`=1.
- Reset mid-operation: assert `areset` with `count`=5 during a frame → next clk `count`=0, `empty`=1, `rx_enbl`=0, `nak_cnt`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants used by the receive-side controller and its FIFO.
package uart_pkg;
    localparam int         UART_OVERSAMPLE = 16;
    localparam int         RX_FIFO_DEPTH   = 16;
    localparam logic [7:0] NAK_CNT_MAX     = 8'hFF;
    localparam int         DIV_MIN         = 2;
endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; the head byte is visible on rdata while not empty.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // A pop frees the slot at the same edge, so a push at full still fits.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: oversample tick generator, parity config gating,
// byte capture into the host FIFO, and NAK / overrun statistics.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             rx_en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             par_en_cfg,
    input  logic             clr_stats,
    output logic             rx_enbl,
    output logic             p_enbl,
    input  logic [7:0]       rx_dout,
    input  logic             rx_flag,
    input  logic             rx_fb,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             overrun,
    output logic             nak_pulse,
    output logic [7:0]       nak_cnt
);
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] eff_div;
    logic             tick_wrap;
    logic [7:0]       dout_q;
    logic             flag_q, flag_qq;
    logic             fb_q, fb_qq;
    logic             push_ev;
    logic             nak_ev;
    logic             drop;
    logic [7:0]       nak_base;

    assign eff_div   = (baud_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : baud_div;
    // ">=" rather than "==" so a shrinking divisor wraps on the next clk.
    assign tick_wrap = (div_cnt >= eff_div - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (areset) begin
            div_cnt <= '0;
            rx_enbl <= 1'b0;
            p_enbl  <= 1'b0;
        end else if (!rx_en) begin
            div_cnt <= '0;
            rx_enbl <= 1'b0;
            p_enbl  <= par_en_cfg;
        end else if (tick_wrap) begin
            div_cnt <= '0;
            rx_enbl <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            rx_enbl <= 1'b0;
        end
    end

    // Receiver outputs settle within a clk, so one capture stage suffices.
    always_ff @(posedge clk) begin
        if (areset) begin
            dout_q  <= '0;
            flag_q  <= 1'b0;
            flag_qq <= 1'b0;
            fb_q    <= 1'b0;
            fb_qq   <= 1'b0;
        end else begin
            dout_q  <= rx_dout;
            flag_q  <= rx_flag;
            flag_qq <= flag_q;
            fb_q    <= rx_fb;
            fb_qq   <= fb_q;
        end
    end

    assign push_ev  = flag_q & ~flag_qq;
    assign nak_ev   = fb_q & ~fb_qq;
    // Host pop protocol: rd_en is a request, accepted only while !empty.
    assign drop     = push_ev & full & ~rd_en;
    assign nak_base = clr_stats ? 8'h00 : nak_cnt;

    always_ff @(posedge clk) begin
        if (areset) begin
            overrun   <= 1'b0;
            nak_pulse <= 1'b0;
            nak_cnt   <= '0;
        end else begin
            nak_pulse <= nak_ev;
            if (drop)           overrun <= 1'b1;
            else if (clr_stats) overrun <= 1'b0;
            if (nak_ev && nak_base != NAK_CNT_MAX) nak_cnt <= nak_base + 1'b1;
            else                                   nak_cnt <= nak_base;
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .areset (areset),
        .push   (push_ev),
        .wdata  (dout_q),
        .pop    (rd_en),
        .rdata  (rd_data),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );
endmodule
